retire_trace_buffer: RTL

//  Parametrised retirement-trace collector for the N-wide superscalar core.
//  - Accepts up to IssueWidth retire records per cycle from the core's per-lane retire outputs.
//  - Compacts valid lanes into program order and buffers them in a circular FIFO.
//  - Drains one record per cycle over a valid/ready port to the table logger / verification monitor.
//  - Gives the core a backpressure signal and reports lost records.

---
 rtl/retire_trace_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/retire_trace_buffer.sv
// Purpose: compacts up to IssueWidth retire records per cycle into program order and queues them for a trace consumer.
// Latency: a record pushed in cycle t is visible at the head (first-word-fall-through) in t+1.
// Backpressure: stall_o is raised when fewer than IssueWidth entries are free; a group that does not fit is dropped whole and overflow_o sticks.
//
// Ports:
//   clk_i, rstn_i           clock, synchronous active-low reset
//   update_i / *_i lanes    per-lane retire valid and record fields, lane 0 oldest
//   trace_valid_o/ready_i   head-record handshake; trace_*_o carry the head record
//   stall_o, overflow_o     retire hold request, sticky drop indication
//   count_o                 occupied entries
//   instret_o               accepted-record counter, present only with RETIRE_TRACE_CNT_EN defined
module retire_trace_buffer #(
    parameter int XLEN       = 32,
    parameter int IssueWidth = 2,
    parameter int Depth      = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [IssueWidth-1:0]                 update_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]       pc_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]       instr_i,
    input  logic [IssueWidth-1:0][4:0]            reg_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]       reg_data_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]       mem_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]       mem_data_i,
    input  logic [IssueWidth-1:0]                 mem_wrt_i,
    output logic                                  trace_valid_o,
    input  logic                                  trace_ready_i,
    output logic [XLEN-1:0]                       trace_pc_o,
    output logic [XLEN-1:0]                       trace_instr_o,
    output logic [4:0]                            trace_reg_addr_o,
    output logic [XLEN-1:0]                       trace_reg_data_o,
    output logic [XLEN-1:0]                       trace_mem_addr_o,
    output logic [XLEN-1:0]                       trace_mem_data_o,
    output logic                                  trace_mem_wrt_o,
    output logic                                  stall_o,
    output logic                                  overflow_o,
`ifdef RETIRE_TRACE_CNT_EN
    output logic [63:0]                           instret_o,
`endif
    output logic [$clog2(Depth+1)-1:0]            count_o
);

    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth+1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(Depth);
    localparam logic [CW-1:0] STALL_TH  = CW'(Depth - IssueWidth);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
    } rec_t;

    rec_t            mem_q [Depth];
    rec_t            lane_rec [IssueWidth];
    logic [PW-1:0]   lane_off [IssueWidth];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   npush;
    logic [CW-1:0]   free;
    logic            push_ok;
    logic            pop;
    rec_t            head;

    // Each valid lane's slot offset is the number of valid lanes below it,
    // which packs the group densely in lane (program) order.
    always_comb begin
        npush = '0;
        for (int l = 0; l < IssueWidth; l++) begin
            lane_off[l] = npush[PW-1:0];
            npush       = npush + CW'(update_i[l]);
            lane_rec[l] = '{pc: pc_i[l], instr: instr_i[l], reg_addr: reg_addr_i[l],
                            reg_data: reg_data_i[l], mem_addr: mem_addr_i[l],
                            mem_data: mem_data_i[l], mem_wrt: mem_wrt_i[l]};
        end
    end

    // Free space uses the registered count only: a pop in the same cycle is
    // not credited, which keeps stall_o and the accept decision input-free.
    assign free          = DEPTH_C - count_q;
    assign push_ok       = (npush <= free);
    assign trace_valid_o = (count_q != '0);
    assign pop           = trace_valid_o && trace_ready_i;
    assign stall_o       = (count_q > STALL_TH);
    assign count_o       = count_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + npush[PW-1:0];
            end else begin
                overflow_o <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (push_ok ? npush : '0) - CW'(pop);
        end
    end

    // Entry storage is never cleared; writes are simply suppressed in reset.
    always_ff @(posedge clk_i) begin
        if (rstn_i && push_ok) begin
            for (int l = 0; l < IssueWidth; l++) begin
                if (update_i[l]) begin
                    mem_q[wr_ptr_q + lane_off[l]] <= lane_rec[l];
                end
            end
        end
    end

`ifdef RETIRE_TRACE_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            instret_o <= '0;
        end else if (push_ok) begin
            instret_o <= instret_o + 64'(npush);
        end
    end
`endif

    assign head             = mem_q[rd_ptr_q];
    assign trace_pc_o       = head.pc;
    assign trace_instr_o    = head.instr;
    assign trace_reg_addr_o = head.reg_addr;
    assign trace_reg_data_o = head.reg_data;
    assign trace_mem_addr_o = head.mem_addr;
    assign trace_mem_data_o = head.mem_data;
    assign trace_mem_wrt_o  = head.mem_wrt;

endmodule
